// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: instruction class bit positions,
// reset PC, multiply/divide opcode encoding and the Tuse/Tnew decrement helper.
package ex_stage_pkg;

    localparam int INSTR_W = 60;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    // Bit positions inside the one-hot InstrType vector
    localparam int IT_ADDU  = 0;
    localparam int IT_SUBU  = 1;
    localparam int IT_ORI   = 2;
    localparam int IT_LW    = 3;
    localparam int IT_SW    = 4;
    localparam int IT_LUI   = 5;
    localparam int IT_SLL   = 6;
    localparam int IT_JAL   = 7;
    localparam int IT_MULT  = 8;
    localparam int IT_MULTU = 9;
    localparam int IT_DIV   = 10;
    localparam int IT_DIVU  = 11;
    localparam int IT_MFHI  = 12;
    localparam int IT_MFLO  = 13;
    localparam int IT_MTHI  = 14;
    localparam int IT_MTLO  = 15;

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } md_op_e;

    // Pipeline distance counters saturate at zero; 7 ("unused") decays like any value
    function automatic logic [2:0] dec_t(input logic [2:0] x);
        logic [2:0] r;
        if (x != 3'd0) r = x - 3'd1;
        else           r = x;
        return r;
    endfunction

endpackage

// File: rtl/ex_stage_mdu.sv
// Multi-cycle multiply/divide unit with HI/LO registers. Operands are captured
// at start; the result is written on the edge where the countdown reaches zero.
module ex_stage_mdu
    import ex_stage_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  md_op_e      op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic [31:0] wdata,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy
);

    logic [3:0]  count_r;
    md_op_e      op_r;
    logic [31:0] a_r;
    logic [31:0] b_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic [63:0] res_s;
    logic        res_ok_s;

    assign hi   = hi_r;
    assign lo   = lo_r;
    assign busy = (count_r != 4'd0);

    // Result of the pending operation; divide by zero leaves HI/LO untouched
    always_comb begin
        res_s    = 64'd0;
        res_ok_s = 1'b1;
        case (op_r)
            MD_MULT:  res_s = $signed({{32{a_r[31]}}, a_r}) * $signed({{32{b_r[31]}}, b_r});
            MD_MULTU: res_s = {32'd0, a_r} * {32'd0, b_r};
            MD_DIV: begin
                if (b_r != 32'd0) begin
                    res_s[31:0]  = $signed(a_r) / $signed(b_r);
                    res_s[63:32] = $signed(a_r) % $signed(b_r);
                end else begin
                    res_ok_s = 1'b0;
                end
            end
            MD_DIVU: begin
                if (b_r != 32'd0) begin
                    res_s[31:0]  = a_r / b_r;
                    res_s[63:32] = a_r % b_r;
                end else begin
                    res_ok_s = 1'b0;
                end
            end
            default: res_ok_s = 1'b0;
        endcase
    end

    // Start/countdown/commit sequencing and direct HI/LO writes when idle
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= 4'd0;
            op_r    <= MD_MULT;
            a_r     <= 32'd0;
            b_r     <= 32'd0;
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
        end else if (count_r == 4'd0) begin
            if (start) begin
                a_r  <= a;
                b_r  <= b;
                op_r <= op;
                if (op == MD_MULT || op == MD_MULTU) count_r <= 4'(MULT_CYCLES);
                else                                 count_r <= 4'(DIV_CYCLES);
            end else if (wr_hi) begin
                hi_r <= wdata;
            end else if (wr_lo) begin
                lo_r <= wdata;
            end
        end else begin
            count_r <= count_r - 4'd1;
            if (count_r == 4'd1 && res_ok_s) begin
                hi_r <= res_s[63:32];
                lo_r <= res_s[31:0];
            end
        end
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, jal link value, multiply/divide unit and the EX/Mem
// pipeline register. Hazard-unit views (indices, decremented Tuse/Tnew,
// md_busy) are combinational.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int          MULT_CYCLES = 5,
    parameter int          DIV_CYCLES  = 10,
    parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] InstrType_ID_to_EX,
    input  logic [31:0]        RSData_ID_to_EX,
    input  logic [31:0]        RTData_ID_to_EX,
    input  logic [15:0]        Imm16_ID_to_EX,
    input  logic [4:0]         Shamt_ID_to_EX,
    input  logic [31:0]        PC_ID_to_EX,
    input  logic [4:0]         RAddr0_ID_to_EX,
    input  logic [4:0]         RAddr1_ID_to_EX,
    input  logic [4:0]         RegWriteAddr_ID_to_EX,
    input  logic [2:0]         Tuse_RAddr0_ID_to_EX,
    input  logic [2:0]         Tuse_RAddr1_ID_to_EX,
    input  logic [2:0]         Tnew_WAddr_ID_to_EX,
    output logic [INSTR_W-1:0] InstrType_EX_to_Mem,
    output logic [31:0]        ALUOut_EX_to_Mem,
    output logic [31:0]        DMWriteData_EX_to_Mem,
    output logic [31:0]        PC_EX_to_Mem,
    output logic [4:0]         RAddr0_EX_to_Mem,
    output logic [4:0]         RAddr1_EX_to_Mem,
    output logic [4:0]         RegWriteAddr_EX_to_Mem,
    output logic [2:0]         Tuse_RAddr0_EX_to_Mem,
    output logic [2:0]         Tuse_RAddr1_EX_to_Mem,
    output logic [2:0]         Tnew_WAddr_EX_to_Mem,
    output logic [4:0]         RAddr0_EX,
    output logic [4:0]         RAddr1_EX,
    output logic [4:0]         RegWriteAddr_EX,
    output logic [2:0]         Tuse_RAddr0_EX,
    output logic [2:0]         Tuse_RAddr1_EX,
    output logic [2:0]         Tnew_WAddr_EX,
    output logic               md_busy
);

    logic        md_start_s;
    md_op_e      md_op_s;
    logic [31:0] hi_s;
    logic [31:0] lo_s;
    logic        mdu_busy_s;
    logic [31:0] imm_zext_s;
    logic [31:0] imm_sext_s;
    logic [31:0] alu_s;

    assign md_start_s = InstrType_ID_to_EX[IT_MULT] | InstrType_ID_to_EX[IT_MULTU] |
                        InstrType_ID_to_EX[IT_DIV]  | InstrType_ID_to_EX[IT_DIVU];
    assign md_busy    = md_start_s | mdu_busy_s;

    assign imm_zext_s = {16'h0000, Imm16_ID_to_EX};
    assign imm_sext_s = {{16{Imm16_ID_to_EX[15]}}, Imm16_ID_to_EX};

    assign RAddr0_EX       = RAddr0_ID_to_EX;
    assign RAddr1_EX       = RAddr1_ID_to_EX;
    assign RegWriteAddr_EX = RegWriteAddr_ID_to_EX;
    assign Tuse_RAddr0_EX  = dec_t(Tuse_RAddr0_ID_to_EX);
    assign Tuse_RAddr1_EX  = dec_t(Tuse_RAddr1_ID_to_EX);
    assign Tnew_WAddr_EX   = dec_t(Tnew_WAddr_ID_to_EX);

    // Map the one-hot multiply/divide class onto the MDU opcode
    always_comb begin
        if (InstrType_ID_to_EX[IT_MULT])       md_op_s = MD_MULT;
        else if (InstrType_ID_to_EX[IT_MULTU]) md_op_s = MD_MULTU;
        else if (InstrType_ID_to_EX[IT_DIV])   md_op_s = MD_DIV;
        else                                   md_op_s = MD_DIVU;
    end

    ex_stage_mdu #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_mdu (
        .clk   (clk),
        .reset (reset),
        .start (md_start_s),
        .op    (md_op_s),
        .a     (RSData_ID_to_EX),
        .b     (RTData_ID_to_EX),
        .wr_hi (InstrType_ID_to_EX[IT_MTHI]),
        .wr_lo (InstrType_ID_to_EX[IT_MTLO]),
        .wdata (RSData_ID_to_EX),
        .hi    (hi_s),
        .lo    (lo_s),
        .busy  (mdu_busy_s)
    );

    // ALU result selection by instruction class; unlisted classes produce zero
    always_comb begin
        alu_s = 32'd0;
        if (InstrType_ID_to_EX[IT_ADDU])      alu_s = RSData_ID_to_EX + RTData_ID_to_EX;
        else if (InstrType_ID_to_EX[IT_SUBU]) alu_s = RSData_ID_to_EX - RTData_ID_to_EX;
        else if (InstrType_ID_to_EX[IT_ORI])  alu_s = RSData_ID_to_EX | imm_zext_s;
        else if (InstrType_ID_to_EX[IT_LW] || InstrType_ID_to_EX[IT_SW])
                                              alu_s = RSData_ID_to_EX + imm_sext_s;
        else if (InstrType_ID_to_EX[IT_LUI])  alu_s = {Imm16_ID_to_EX, 16'h0000};
        else if (InstrType_ID_to_EX[IT_SLL])  alu_s = RTData_ID_to_EX << Shamt_ID_to_EX;
        else if (InstrType_ID_to_EX[IT_JAL])  alu_s = PC_ID_to_EX + 32'd8;
        else if (InstrType_ID_to_EX[IT_MFHI]) alu_s = hi_s;
        else if (InstrType_ID_to_EX[IT_MFLO]) alu_s = lo_s;
        else                                  alu_s = 32'd0;
    end

    // EX/Mem pipeline register, loaded every cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            InstrType_EX_to_Mem    <= '0;
            ALUOut_EX_to_Mem       <= 32'd0;
            DMWriteData_EX_to_Mem  <= 32'd0;
            PC_EX_to_Mem           <= RESET_PC;
            RAddr0_EX_to_Mem       <= 5'd0;
            RAddr1_EX_to_Mem       <= 5'd0;
            RegWriteAddr_EX_to_Mem <= 5'd0;
            Tuse_RAddr0_EX_to_Mem  <= 3'b111;
            Tuse_RAddr1_EX_to_Mem  <= 3'b111;
            Tnew_WAddr_EX_to_Mem   <= 3'b000;
        end else begin
            InstrType_EX_to_Mem    <= InstrType_ID_to_EX;
            ALUOut_EX_to_Mem       <= alu_s;
            DMWriteData_EX_to_Mem  <= RTData_ID_to_EX;
            PC_EX_to_Mem           <= PC_ID_to_EX;
            RAddr0_EX_to_Mem       <= RAddr0_ID_to_EX;
            RAddr1_EX_to_Mem       <= RAddr1_ID_to_EX;
            RegWriteAddr_EX_to_Mem <= RegWriteAddr_ID_to_EX;
            Tuse_RAddr0_EX_to_Mem  <= Tuse_RAddr0_EX;
            Tuse_RAddr1_EX_to_Mem  <= Tuse_RAddr1_EX;
            Tnew_WAddr_EX_to_Mem   <= Tnew_WAddr_EX;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed instruction vectors, a behavioural
// model compared every cycle, and hand-computed literal expectations.
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic               clk = 1'b0;
    logic               reset;
    logic [INSTR_W-1:0] InstrType_ID_to_EX;
    logic [31:0]        RSData_ID_to_EX, RTData_ID_to_EX, PC_ID_to_EX;
    logic [15:0]        Imm16_ID_to_EX;
    logic [4:0]         Shamt_ID_to_EX, RAddr0_ID_to_EX, RAddr1_ID_to_EX, RegWriteAddr_ID_to_EX;
    logic [2:0]         Tuse_RAddr0_ID_to_EX, Tuse_RAddr1_ID_to_EX, Tnew_WAddr_ID_to_EX;
    logic [INSTR_W-1:0] InstrType_EX_to_Mem;
    logic [31:0]        ALUOut_EX_to_Mem, DMWriteData_EX_to_Mem, PC_EX_to_Mem;
    logic [4:0]         RAddr0_EX_to_Mem, RAddr1_EX_to_Mem, RegWriteAddr_EX_to_Mem;
    logic [2:0]         Tuse_RAddr0_EX_to_Mem, Tuse_RAddr1_EX_to_Mem, Tnew_WAddr_EX_to_Mem;
    logic [4:0]         RAddr0_EX, RAddr1_EX, RegWriteAddr_EX;
    logic [2:0]         Tuse_RAddr0_EX, Tuse_RAddr1_EX, Tnew_WAddr_EX;
    logic               md_busy;

    ex_stage dut (
        .clk(clk), .reset(reset),
        .InstrType_ID_to_EX(InstrType_ID_to_EX), .RSData_ID_to_EX(RSData_ID_to_EX),
        .RTData_ID_to_EX(RTData_ID_to_EX), .Imm16_ID_to_EX(Imm16_ID_to_EX),
        .Shamt_ID_to_EX(Shamt_ID_to_EX), .PC_ID_to_EX(PC_ID_to_EX),
        .RAddr0_ID_to_EX(RAddr0_ID_to_EX), .RAddr1_ID_to_EX(RAddr1_ID_to_EX),
        .RegWriteAddr_ID_to_EX(RegWriteAddr_ID_to_EX),
        .Tuse_RAddr0_ID_to_EX(Tuse_RAddr0_ID_to_EX), .Tuse_RAddr1_ID_to_EX(Tuse_RAddr1_ID_to_EX),
        .Tnew_WAddr_ID_to_EX(Tnew_WAddr_ID_to_EX),
        .InstrType_EX_to_Mem(InstrType_EX_to_Mem), .ALUOut_EX_to_Mem(ALUOut_EX_to_Mem),
        .DMWriteData_EX_to_Mem(DMWriteData_EX_to_Mem), .PC_EX_to_Mem(PC_EX_to_Mem),
        .RAddr0_EX_to_Mem(RAddr0_EX_to_Mem), .RAddr1_EX_to_Mem(RAddr1_EX_to_Mem),
        .RegWriteAddr_EX_to_Mem(RegWriteAddr_EX_to_Mem),
        .Tuse_RAddr0_EX_to_Mem(Tuse_RAddr0_EX_to_Mem), .Tuse_RAddr1_EX_to_Mem(Tuse_RAddr1_EX_to_Mem),
        .Tnew_WAddr_EX_to_Mem(Tnew_WAddr_EX_to_Mem),
        .RAddr0_EX(RAddr0_EX), .RAddr1_EX(RAddr1_EX), .RegWriteAddr_EX(RegWriteAddr_EX),
        .Tuse_RAddr0_EX(Tuse_RAddr0_EX), .Tuse_RAddr1_EX(Tuse_RAddr1_EX),
        .Tnew_WAddr_EX(Tnew_WAddr_EX), .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    bit cmp_en = 1'b0;
    int cur_cls = -1;

    // Behavioural model state
    logic [INSTR_W-1:0] exp_instr;
    logic [31:0] exp_alu, exp_dm, exp_pc, m_hi, m_lo;
    logic [4:0]  exp_ra0, exp_ra1, exp_wa;
    logic [2:0]  exp_tu0, exp_tu1, exp_tn;
    logic [63:0] m_pend;
    bit          m_pend_ok;
    int          m_rem;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [2:0] m_dec(input logic [2:0] x);
        return (x == 3'd0) ? x : x - 3'd1;
    endfunction

    function automatic bit is_md_start(input int cls);
        return cls == IT_MULT || cls == IT_MULTU || cls == IT_DIV || cls == IT_DIVU;
    endfunction

    // {HI,LO} a finished mult/div must produce
    function automatic logic [63:0] md_result(input int cls, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        int q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (cls == IT_MULT) return sa * sb;
        if (cls == IT_MULTU) return {32'd0, a} * {32'd0, b};
        if (b == 32'd0) return 64'd0;
        if (cls == IT_DIV) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
            return {r, q};
        end
        return {a % b, a / b};
    endfunction

    function automatic logic [31:0] model_alu(input int cls, input logic [31:0] rs, input logic [31:0] rt,
                                              input logic [15:0] imm, input logic [4:0] sh,
                                              input logic [31:0] pc, input logic [31:0] hi, input logic [31:0] lo);
        int simm;
        simm = int'($signed(imm));
        case (cls)
            IT_ADDU:      return rs + rt;
            IT_SUBU:      return rs - rt;
            IT_ORI:       return rs | {16'd0, imm};
            IT_LW, IT_SW: return rs + simm;
            IT_LUI:       return {imm, 16'd0};
            IT_SLL:       return rt << sh;
            IT_JAL:       return pc + 32'd8;
            IT_MFHI:      return hi;
            IT_MFLO:      return lo;
            default:      return 32'd0;
        endcase
    endfunction

    // Model: what the EX/Mem register and HI/LO must hold after each edge
    always @(posedge clk) begin
        if (reset) begin
            exp_instr <= '0; exp_alu <= 32'd0; exp_dm <= 32'd0; exp_pc <= 32'h0000_3000;
            exp_ra0 <= 5'd0; exp_ra1 <= 5'd0; exp_wa <= 5'd0;
            exp_tu0 <= 3'd7; exp_tu1 <= 3'd7; exp_tn <= 3'd0;
            m_hi <= 32'd0; m_lo <= 32'd0; m_rem <= 0; m_pend <= 64'd0; m_pend_ok <= 1'b0;
        end else begin
            exp_instr <= InstrType_ID_to_EX;
            exp_alu   <= model_alu(cur_cls, RSData_ID_to_EX, RTData_ID_to_EX, Imm16_ID_to_EX,
                                   Shamt_ID_to_EX, PC_ID_to_EX, m_hi, m_lo);
            exp_dm  <= RTData_ID_to_EX;
            exp_pc  <= PC_ID_to_EX;
            exp_ra0 <= RAddr0_ID_to_EX;
            exp_ra1 <= RAddr1_ID_to_EX;
            exp_wa  <= RegWriteAddr_ID_to_EX;
            exp_tu0 <= m_dec(Tuse_RAddr0_ID_to_EX);
            exp_tu1 <= m_dec(Tuse_RAddr1_ID_to_EX);
            exp_tn  <= m_dec(Tnew_WAddr_ID_to_EX);
            if (m_rem == 0) begin
                if (is_md_start(cur_cls)) begin
                    m_rem     <= (cur_cls == IT_MULT || cur_cls == IT_MULTU) ? 5 : 10;
                    m_pend    <= md_result(cur_cls, RSData_ID_to_EX, RTData_ID_to_EX);
                    m_pend_ok <= !((cur_cls == IT_DIV || cur_cls == IT_DIVU) && RTData_ID_to_EX == 32'd0);
                end else if (cur_cls == IT_MTHI) begin
                    m_hi <= RSData_ID_to_EX;
                end else if (cur_cls == IT_MTLO) begin
                    m_lo <= RSData_ID_to_EX;
                end
            end else begin
                m_rem <= m_rem - 1;
                if (m_rem == 1 && m_pend_ok) begin
                    m_hi <= m_pend[63:32];
                    m_lo <= m_pend[31:0];
                end
            end
        end
    end

    // Compare process: every cycle, away from the active edge
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("instr_reg", 64'(InstrType_EX_to_Mem), 64'(exp_instr));
            chk("aluout_reg", 64'(ALUOut_EX_to_Mem), 64'(exp_alu));
            chk("dmwdata_reg", 64'(DMWriteData_EX_to_Mem), 64'(exp_dm));
            chk("pc_reg", 64'(PC_EX_to_Mem), 64'(exp_pc));
            chk("raddr0_reg", 64'(RAddr0_EX_to_Mem), 64'(exp_ra0));
            chk("raddr1_reg", 64'(RAddr1_EX_to_Mem), 64'(exp_ra1));
            chk("waddr_reg", 64'(RegWriteAddr_EX_to_Mem), 64'(exp_wa));
            chk("tuse0_reg", 64'(Tuse_RAddr0_EX_to_Mem), 64'(exp_tu0));
            chk("tuse1_reg", 64'(Tuse_RAddr1_EX_to_Mem), 64'(exp_tu1));
            chk("tnew_reg", 64'(Tnew_WAddr_EX_to_Mem), 64'(exp_tn));
            chk("raddr0_ex", 64'(RAddr0_EX), 64'(RAddr0_ID_to_EX));
            chk("raddr1_ex", 64'(RAddr1_EX), 64'(RAddr1_ID_to_EX));
            chk("waddr_ex", 64'(RegWriteAddr_EX), 64'(RegWriteAddr_ID_to_EX));
            chk("tuse0_ex", 64'(Tuse_RAddr0_EX), 64'(m_dec(Tuse_RAddr0_ID_to_EX)));
            chk("tuse1_ex", 64'(Tuse_RAddr1_EX), 64'(m_dec(Tuse_RAddr1_ID_to_EX)));
            chk("tnew_ex", 64'(Tnew_WAddr_EX), 64'(m_dec(Tnew_WAddr_ID_to_EX)));
            chk("md_busy", 64'(md_busy), 64'(is_md_start(cur_cls) || m_rem != 0));
        end
    end

    // Present one instruction in EX (cls < 0 is a bubble)
    task automatic drive(input int cls, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [15:0] imm, input logic [4:0] sh, input logic [31:0] pc);
        cur_cls               = cls;
        InstrType_ID_to_EX    = (cls >= 0) ? (60'd1 << cls) : 60'd0;
        RSData_ID_to_EX       = rs;
        RTData_ID_to_EX       = rt;
        Imm16_ID_to_EX        = imm;
        Shamt_ID_to_EX        = sh;
        PC_ID_to_EX           = pc;
        RAddr0_ID_to_EX       = 5'(cls + 1);
        RAddr1_ID_to_EX       = 5'(cls + 7);
        RegWriteAddr_ID_to_EX = 5'(cls + 13);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int cls, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [15:0] imm, input logic [31:0] pc);
        drive(cls, rs, rt, imm, 5'd0, pc);
        tick();
    endtask

    task automatic bubble();
        issue(-1, 32'd0, 32'd0, 16'd0, 32'h0000_3000);
    endtask

    initial begin
        reset = 1'b1;
        Tuse_RAddr0_ID_to_EX = 3'd7;
        Tuse_RAddr1_ID_to_EX = 3'd7;
        Tnew_WAddr_ID_to_EX  = 3'd0;
        drive(-1, 32'd0, 32'd0, 16'd0, 5'd0, 32'h0000_5000);
        tick();
        cmp_en = 1'b1;
        reset  = 1'b0;
        chk("rst_pc", 64'(PC_EX_to_Mem), 64'h3000);
        chk("rst_tuse0", 64'(Tuse_RAddr0_EX_to_Mem), 64'd7);
        chk("rst_tuse1", 64'(Tuse_RAddr1_EX_to_Mem), 64'd7);
        chk("rst_tnew", 64'(Tnew_WAddr_EX_to_Mem), 64'd0);
        chk("rst_busy", 64'(md_busy), 64'd0);
        issue(IT_MFHI, 32'd0, 32'd0, 16'd0, 32'h3000);
        chk("rst_hi", 64'(ALUOut_EX_to_Mem), 64'd0);
        issue(IT_MFLO, 32'd0, 32'd0, 16'd0, 32'h3004);
        chk("rst_lo", 64'(ALUOut_EX_to_Mem), 64'd0);

        // ALU classes
        issue(IT_ADDU, 32'hFFFF_FFFF, 32'd2, 16'd0, 32'h3000);
        chk("addu_wrap", 64'(ALUOut_EX_to_Mem), 64'h1);
        Tnew_WAddr_ID_to_EX  = 3'd2;
        Tuse_RAddr0_ID_to_EX = 3'd0;
        drive(IT_SUBU, 32'd5, 32'd7, 16'd0, 5'd0, 32'h3004);
        chk("tnew_ex_lit", 64'(Tnew_WAddr_EX), 64'd1);
        chk("tuse0_ex_lit", 64'(Tuse_RAddr0_EX), 64'd0);
        tick();
        chk("tnew_reg_lit", 64'(Tnew_WAddr_EX_to_Mem), 64'd1);
        chk("tuse0_reg_lit", 64'(Tuse_RAddr0_EX_to_Mem), 64'd0);
        chk("subu_wrap", 64'(ALUOut_EX_to_Mem), 64'hFFFF_FFFE);
        Tnew_WAddr_ID_to_EX  = 3'd7;
        Tuse_RAddr0_ID_to_EX = 3'd3;
        Tuse_RAddr1_ID_to_EX = 3'd1;
        issue(IT_LW, 32'h10, 32'h0, 16'hFFFC, 32'h3008);
        chk("lw_addr", 64'(ALUOut_EX_to_Mem), 64'hC);
        chk("tnew7_reg", 64'(Tnew_WAddr_EX_to_Mem), 64'd6);
        Tnew_WAddr_ID_to_EX  = 3'd0;
        Tuse_RAddr0_ID_to_EX = 3'd7;
        Tuse_RAddr1_ID_to_EX = 3'd7;
        issue(IT_SW, 32'h100, 32'hCAFE_BABE, 16'h0020, 32'h300C);
        chk("sw_addr", 64'(ALUOut_EX_to_Mem), 64'h120);
        chk("sw_data", 64'(DMWriteData_EX_to_Mem), 64'hCAFE_BABE);
        issue(IT_LUI, 32'hFFFF_FFFF, 32'd0, 16'h1234, 32'h3010);
        chk("lui", 64'(ALUOut_EX_to_Mem), 64'h1234_0000);
        issue(IT_JAL, 32'd0, 32'd0, 16'd0, 32'h3008);
        chk("jal", 64'(ALUOut_EX_to_Mem), 64'h3010);
        issue(IT_ORI, 32'hF000_0000, 32'd0, 16'h8001, 32'h3014);
        chk("ori_zext", 64'(ALUOut_EX_to_Mem), 64'hF000_8001);
        drive(IT_SLL, 32'd0, 32'h0000_00F1, 16'd0, 5'd4, 32'h3018);
        tick();
        chk("sll", 64'(ALUOut_EX_to_Mem), 64'hF10);

        // mult -3 * 5, with an mthi arriving while busy (must be ignored)
        drive(IT_MULT, 32'hFFFF_FFFD, 32'd5, 16'd0, 5'd0, 32'h3020);
        chk("mult_busy_start", 64'(md_busy), 64'd1);
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("mult_busy", 64'(md_busy), 64'd1);
            if (k == 2) issue(IT_MTHI, 32'hDEAD_0000, 32'd0, 16'd0, 32'h3024);
            else        bubble();
        end
        chk("mult_idle", 64'(md_busy), 64'd0);
        issue(IT_MFLO, 32'd0, 32'd0, 16'd0, 32'h3028);
        chk("mult_lo", 64'(ALUOut_EX_to_Mem), 64'hFFFF_FFF1);
        issue(IT_MFHI, 32'd0, 32'd0, 16'd0, 32'h302C);
        chk("mult_hi", 64'(ALUOut_EX_to_Mem), 64'hFFFF_FFFF);

        // multu large operands
        issue(IT_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 16'd0, 32'h3030);
        for (int k = 0; k < 5; k++) bubble();
        issue(IT_MFHI, 32'd0, 32'd0, 16'd0, 32'h3034);
        chk("multu_hi", 64'(ALUOut_EX_to_Mem), 64'h1);

        // div -7 / 2
        issue(IT_DIV, 32'hFFFF_FFF9, 32'd2, 16'd0, 32'h3040);
        for (int k = 0; k < 10; k++) begin
            chk("div_busy", 64'(md_busy), 64'd1);
            bubble();
        end
        chk("div_idle", 64'(md_busy), 64'd0);
        issue(IT_MFLO, 32'd0, 32'd0, 16'd0, 32'h3044);
        chk("div_lo", 64'(ALUOut_EX_to_Mem), 64'hFFFF_FFFD);
        issue(IT_MFHI, 32'd0, 32'd0, 16'd0, 32'h3048);
        chk("div_hi", 64'(ALUOut_EX_to_Mem), 64'hFFFF_FFFF);

        // divu by zero keeps HI/LO written by mthi/mtlo
        issue(IT_MTHI, 32'hAAAA_5555, 32'd0, 16'd0, 32'h3050);
        issue(IT_MTLO, 32'h1234_5678, 32'd0, 16'd0, 32'h3054);
        issue(IT_DIVU, 32'd5, 32'd0, 16'd0, 32'h3058);
        for (int k = 0; k < 10; k++) bubble();
        issue(IT_MFHI, 32'd0, 32'd0, 16'd0, 32'h305C);
        chk("divu0_hi", 64'(ALUOut_EX_to_Mem), 64'hAAAA_5555);
        issue(IT_MFLO, 32'd0, 32'd0, 16'd0, 32'h3060);
        chk("divu0_lo", 64'(ALUOut_EX_to_Mem), 64'h1234_5678);

        // divu 100 / 7
        issue(IT_DIVU, 32'd100, 32'd7, 16'd0, 32'h3064);
        for (int k = 0; k < 10; k++) bubble();
        issue(IT_MFHI, 32'd0, 32'd0, 16'd0, 32'h3068);
        chk("divu_hi", 64'(ALUOut_EX_to_Mem), 64'd2);

        // reset during the 3rd busy cycle of a div
        issue(IT_DIV, 32'd1000, 32'd3, 16'd0, 32'h3070);
        bubble();
        reset = 1'b1;
        bubble();
        reset = 1'b0;
        chk("rst_mid_busy", 64'(md_busy), 64'd0);
        chk("rst_mid_pc", 64'(PC_EX_to_Mem), 64'h3000);
        issue(IT_MFHI, 32'd0, 32'd0, 16'd0, 32'h3074);
        chk("rst_mid_hi", 64'(ALUOut_EX_to_Mem), 64'd0);
        issue(IT_MFLO, 32'd0, 32'd0, 16'd0, 32'h3078);
        chk("rst_mid_lo", 64'(ALUOut_EX_to_Mem), 64'd0);
        for (int k = 0; k < 12; k++) begin
            chk("rst_mid_stays_idle", 64'(md_busy), 64'd0);
            bubble();
        end

        @(negedge clk);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
